// File: rtl/syn_fifo_reader.sv
// Read-side drain engine: pops the FIFO, absorbs its one-cycle read latency
// in a 2-entry skid buffer and presents words on a valid/ready stream.
module syn_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  occ_e                  occ, occ_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head, tail;
  logic                  accept, capture;
  logic [1:0]            occ_cnt, level;

  assign m_valid    = (occ != EMPTY);
  assign m_data     = head;
  assign accept     = m_valid && m_ready;
  assign capture    = inflight && !flush;
  assign occ_cnt    = occ;
  // Words popped but not yet accepted: buffered plus the one on the read port.
  assign level      = occ_cnt + {1'b0, inflight};
  assign fifo_rd_en = rst_n && !flush && !fifo_empty &&
                      ((level <= 2'd1) || (level == 2'd2 && accept));
  assign fifo_rd_cs = fifo_rd_en;

  always_comb begin
    occ_nxt = occ;
    if (flush) begin
      occ_nxt = EMPTY;
    end else begin
      case (occ)
        EMPTY:   if (capture) occ_nxt = ONE;
        ONE: begin
          if (capture && !accept)      occ_nxt = TWO;
          else if (accept && !capture) occ_nxt = EMPTY;
        end
        TWO:     if (accept && !capture) occ_nxt = ONE;
        default: occ_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= EMPTY;
      inflight <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      inflight <= fifo_rd_en;
    end
  end

  // Landing word goes to head only if the buffer drains empty this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      if (accept && occ == TWO) head <= tail;
      if (capture) begin
        if (occ == EMPTY || (occ == ONE && accept)) head <= fifo_data;
        else                                         tail <= fifo_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_count <= '0;
    else        rd_count <= rd_count + CNT_WIDTH'(accept);
  end

endmodule
